// File: rtl/start_stop_button.sv
// Push-button conditioner: synchroniser, two-way debounce FSM and
// registered press/release/long-hold pulses for the START/STOP toggle.
module start_stop_button #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 200_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_db,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          long_done_q, long_done_d;
    logic          btn_db_q, btn_db_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            btn_db_q    <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_done_q <= long_done_d;
            btn_db_q    <= btn_db_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s1_d        = btn_in;
        s2_d        = s1_q;
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d   = PRESS_WAIT;
                    deb_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d     = PRESSED;
                    press_d     = 1'b1;
                    hold_cnt_d  = '0;
                    long_done_d = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!s2_q) begin
                    state_d   = RELEASE_WAIT;
                    deb_cnt_d = '0;
                end else if (!long_done_q) begin
                    // hold_cnt freezes once long fires, so it cannot wrap
                    if (hold_cnt_q == HOLD_LAST) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (s2_q) begin
                    state_d = PRESSED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        btn_db_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    assign btn_db        = btn_db_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

endmodule
